axi4_lite_master_bridge: RTL
============================

Name: axi4_lite_master_bridge

Overview:
- Upstream neighbour of the AXI4-Lite slave: converts the core's single-beat load/store request into AXI4-Lite master transactions on an axi4_lite_if bundle.
- Holds the core via busy until the transaction's response handshake completes, then returns read data and error status.
- One outstanding transaction at a time; write and read channels are never active together.

Parameters:
- ADDR_WIDTH, 32, address width of the request side and AWADDR/ARADDR.
- DATA_WIDTH, 32, data width of the request side and WDATA/RDATA. Only 32 is supported; WSTRB is 4 bits.
- TIMEOUT_CYCLES, 256, response-wait limit. Used only when AXI_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- mem_write  in  1  store request, sampled only in IDLE.
- mem_read  in  1  load request, sampled only in IDLE.
- byte_en  in  4  store byte enables; driven onto WSTRB.
- addr  in  ADDR_WIDTH  request address.
- write_data  in  DATA_WIDTH  store data.
- busy  out  1  high whenever state != IDLE (combinational from state).
- read_data  out  DATA_WIDTH  registered load data; holds its value until the next load completes.
- read_valid  out  1  one-cycle pulse when read_data updates.
- resp_err  out  1  one-cycle pulse with read_valid, or at write completion, when the response is not OKAY.
- master_if  bundle  axi4_lite_if  master side; drives AW/W/AR channels plus BREADY and RREADY.

Behaviour:
- Reset (rst=0), forced asynchronously:
  - state=IDLE.
  - AWVALID, WVALID, ARVALID, BREADY, RREADY = 0.
  - AWADDR, ARADDR, WDATA, WSTRB = 0.
  - read_data=0, read_valid=0, resp_err=0, busy=0.
- Reset mid-transaction: all VALID/READY signals drop in the same instant; the transaction is abandoned; no read_valid pulse.
- IDLE:
  - mem_write=1: latch addr/write_data/byte_en into AWADDR/WDATA/WSTRB; next state WR.
  - Else mem_read=1: latch addr into ARADDR; next state RD_ADDR.
  - Both high: write wins; the read is dropped, and the core must re-issue it.
- WR:
  - AWVALID and WVALID both rise on the cycle after acceptance.
  - Each drops independently on the clock after its own VALID&READY.
  - AWREADY and WREADY may arrive in either order or in the same cycle.
  - Once both have been handshaken, go to WR_RESP.
- WR_RESP:
  - BREADY=1.
  - On BVALID: capture BRESP; resp_err pulses next cycle if BRESP!=2'b00; return to IDLE.
- RD_ADDR:
  - ARVALID=1 until ARREADY; go to RD_DATA on the handshake cycle's clock.
- RD_DATA:
  - RREADY=1.
  - On RVALID: read_data<=RDATA; read_valid pulses next cycle; resp_err<=(RRESP!=2'b00); return to IDLE.
- Completion timing: busy falls in the same cycle read_valid/resp_err pulse.
- VALID stability: address/data/strobe are stable while VALID is high; no VALID is withdrawn before its READY (reset excepted).
- Best-case latency, request at cycle N with slave readies high:
  - Read: ARVALID at N+1; RVALID earliest at N+2; read_valid at N+3.
  - Write: AW/W at N+1; BVALID earliest at N+2; busy low at N+3.
- Unused inputs: addr bits [1:0] pass through unchanged; byte_en is ignored for reads.

Optional Feature:
- Macro AXI_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WR_RESP/RD_DATA and increments each cycle while waiting.
  - On reaching TIMEOUT_CYCLES, drop BREADY/RREADY and return to IDLE.
  - Pulse resp_err; for reads, also set read_data=32'hDEAD_BEEF and pulse read_valid.
  - A later late BVALID/RVALID is ignored.
- Undefined: no counter; waits indefinitely.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - Response codes: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Master state enum: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA.
  - Timeout read pattern constant.
- No sub-module: a single FSM with two small AW/W "done" flags.

Test Plan:
- Write, ready-always slave: mem_write=1, addr=32'h1000_0004, data=32'hA5A5_5A5A, byte_en=4'b0011 -> AW/W valid at N+1 with WSTRB=4'b0011; BRESP=OKAY; busy low at N+3; resp_err=0.
- Staggered readies: AWREADY at N+4, WREADY at N+1 -> WVALID low from N+2; AWVALID held until N+4; BREADY rises only after both handshakes.
- Read with RDATA=32'h1234_5678 after 3-cycle RVALID delay -> read_valid pulse carries 32'h1234_5678; ARVALID held at a stable ARADDR until ARREADY.
- Error responses: RRESP=2'b10 -> resp_err and read_valid pulse together; BRESP=2'b11 -> resp_err pulse with no read_valid.
- mem_write and mem_read high together in IDLE -> only the AW/W channels activate; ARVALID never rises.
- Reset and timeout:
  - rst=0 during WR_RESP -> BREADY, busy and all VALIDs are 0 without waiting for a clock edge.
  - With AXI_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, no RVALID -> after 8 wait cycles, read_data=32'hDEAD_BEEF with read_valid and resp_err pulses.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM encoding and the
// read-data pattern returned when a response wait times out.
package axi4_lite_pkg;

    // AXI4-Lite response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Master FSM encoding (plain constants so legacy code can compare raw bits)
    typedef logic [2:0] state_t;
    localparam state_t IDLE    = 3'd0;
    localparam state_t WR      = 3'd1;
    localparam state_t WR_RESP = 3'd2;
    localparam state_t RD_ADDR = 3'd3;
    localparam state_t RD_DATA = 3'd4;

    // Load data handed back when the slave never answers
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Anything other than OKAY is reported to the core as an error; EXOKAY has
    // no meaning for a single-beat master that never issues exclusives.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY:                             err = 1'b0;
            RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                               err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite signal bundle (AW, W, B, AR, R channels; no PROT).
// Ports: none; modports
//   master - drives AW/W/AR payload+VALID, BREADY, RREADY
//   slave  - drives AWREADY, WREADY, B channel, ARREADY, R channel
interface axi4_lite_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4_lite_master_bridge.sv
// Converts a core's single-beat load/store request into one AXI4-Lite
// transaction at a time, stalling the core via busy until the response
// handshake completes.
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   mem_write, mem_read - store/load request, sampled only in IDLE (write wins)
//   byte_en             - store byte enables (WSTRB)
//   addr, write_data    - request address and store data
//   busy                - high whenever a transaction is in flight
//   read_data           - registered load data, held until the next load completes
//   read_valid          - one-cycle pulse when read_data updates
//   resp_err            - one-cycle pulse at completion when the response is not OKAY
//   master_if           - AXI4-Lite master side
//
// Build option: define AXI_TIMEOUT_EN to abandon a response wait after
// TIMEOUT_CYCLES cycles (reads then return TIMEOUT_RDATA with resp_err).
module axi4_lite_master_bridge
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic [3:0]            byte_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  resp_err,
    axi4_lite_if.master           master_if
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axi4_lite_master_bridge: only DATA_WIDTH=32 is supported");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("axi4_lite_master_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                  state_q, state_d;
    // awvalid_q/wvalid_q double as the per-channel "not yet handshaken" flags
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic                    read_valid_q, read_valid_d;
    logic                    resp_err_q, resp_err_d;

`ifdef AXI_TIMEOUT_EN
    localparam int unsigned       CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    // Last waiting cycle: the wait is abandoned after TIMEOUT_CYCLES cycles
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]             cnt_q, cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        awaddr_d     = awaddr_q;
        araddr_d     = araddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        resp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    awaddr_d  = addr;
                    wdata_d   = write_data;
                    wstrb_d   = byte_en;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR;
                end else if (mem_read) begin
                    araddr_d = addr;
                    state_d  = RD_ADDR;
                end
            end
            WR: begin
                if (awvalid_q && master_if.awready) awvalid_d = 1'b0;
                if (wvalid_q && master_if.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)        state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (master_if.bvalid) begin
                    resp_err_d = resp_is_err(master_if.bresp);
                    state_d    = IDLE;
                end
            end
            RD_ADDR: begin
                if (master_if.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (master_if.rvalid) begin
                    read_data_d  = master_if.rdata;
                    read_valid_d = 1'b1;
                    resp_err_d   = resp_is_err(master_if.rresp);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef AXI_TIMEOUT_EN
        // Counter sits at zero outside a response wait, so it is clear on entry
        cnt_d = '0;
        if ((state_q == WR_RESP && !master_if.bvalid) ||
            (state_q == RD_DATA && !master_if.rvalid)) begin
            if (cnt_q == TIMEOUT_LAST) begin
                state_d    = IDLE;
                resp_err_d = 1'b1;
                if (state_q == RD_DATA) begin
                    read_data_d  = DATA_WIDTH'(TIMEOUT_RDATA);
                    read_valid_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

`ifdef AXI_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Channel controls decode straight from state so reset drops them at once
    assign busy              = (state_q != IDLE);
    assign master_if.arvalid = (state_q == RD_ADDR);
    assign master_if.bready  = (state_q == WR_RESP);
    assign master_if.rready  = (state_q == RD_DATA);
    assign master_if.awvalid = awvalid_q;
    assign master_if.wvalid  = wvalid_q;
    assign master_if.awaddr  = awaddr_q;
    assign master_if.araddr  = araddr_q;
    assign master_if.wdata   = wdata_q;
    assign master_if.wstrb   = wstrb_q;

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign resp_err   = resp_err_q;

endmodule
